montgomery_job_sched: RTL and testbench
=======================================

Name: montgomery_job_sched

Overview:
Round-robin scheduler that shares one montgomery_bs bit-serial core among NUM_REQ requesters. It holds the modulus configuration (m, minv, bit length) and drives the core's start pulse and operands. It collects the core result and returns it to the granted requester with an error flag. It sits between the NTT/poly-arith clients and the single Montgomery reduction core.

Parameters:
DATA_LENGTH, 64, operand/result width (matches params_pkg)
NUM_REQ, 4, number of requesters (≥2)
TIMEOUT_CYCLES, 256, max WAIT cycles before abort

Ports:
clk_i  in  1  rising-edge clock
rst_ni  in  1  asynchronous active-low reset
cfg_we_i  in  1  config write strobe
cfg_m_i  in  DATA_LENGTH  modulus
cfg_minv_i  in  DATA_LENGTH  modular inverse
cfg_m_bl_i  in  DATA_LENGTH  modulus bit length
cfg_err_o  out  1  one-cycle pulse: config write rejected
req_valid_i  in  NUM_REQ  per-requester job valid
req_x_i  in  NUM_REQ*DATA_LENGTH  per-requester operand, slice i = requester i
req_ready_o  out  NUM_REQ  one-hot accept
rsp_valid_o  out  NUM_REQ  one-hot response valid
rsp_ready_i  in  NUM_REQ  per-requester response accept
rsp_result_o  out  DATA_LENGTH  shared result bus
rsp_err_o  out  1  response carries error (no config / timeout)
core_start_o  out  1  core start pulse
core_x_o, core_m_o, core_minv_o, core_m_bl_o  out  DATA_LENGTH each  core operands
core_result_i  in  DATA_LENGTH  core result
core_valid_i  in  1  core done
busy_o  out  1  high in any state except IDLE
timeout_o  out  1  one-cycle pulse on abort

Behaviour:
- Reset (async): state=IDLE, rr_ptr=0, cfg_valid=0, all config regs=0, all outputs 0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE, arbitration:
  - grant g = first i with req_valid_i[i], searching from rr_ptr upward with wrap.
  - req_ready_o[g]=1 combinationally in the same cycle (only in IDLE). The handshake completes that cycle.
  - On handshake: latch x=req_x_i slice g and gnt=g.
  - If cfg_valid=1, go to START. If cfg_valid=0, load result=0 and err=1, then go to RESP without starting the core.
- START: core_start_o=1 for exactly one cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - core_valid_i=1: latch result=core_result_i, err=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without core_valid_i: pulse timeout_o, result=0, err=1, go to RESP.
  - If core_valid_i and timeout coincide, core_valid_i wins.
- core_valid_i outside WAIT is ignored.
- RESP:
  - rsp_valid_o[gnt]=1. rsp_result_o and rsp_err_o are stable until rsp_ready_i[gnt]=1.
  - On that handshake: rr_ptr=(gnt+1) mod NUM_REQ, go to IDLE.
  - rsp_ready_i of other requesters is ignored. rsp_result_o=0 when no rsp_valid_o is set.
- Config register writes:
  - Accepted only in IDLE with cfg_m_bl_i≠0 and cfg_m_bl_i≤DATA_LENGTH. On accept, registers load and cfg_valid=1.
  - Any other cfg_we_i gives a one-cycle cfg_err_o pulse and leaves the registers unchanged.
  - If cfg_we_i and a request handshake occur in the same IDLE cycle, the config write takes effect first. The accepted job uses the new config (decision made on the next-state cfg_valid).
- Core operand outputs:
  - core_x_o holds the latched x.
  - core_m_o, core_minv_o and core_m_bl_o are driven from the config registers at all times and are stable for the whole START/WAIT window.
- Timing and throughput:
  - Latency from req handshake to rsp_valid_o is 2 + core latency cycles.
  - At most one job is in flight. Minimum of 3 + core latency cycles between grants.
- Reset mid-operation: immediate return to the reset state. In-flight job is dropped, and no response is produced after reset.

Test Plan:
- Reset, no config, req_valid_i=4'b0001, x=0x10: req_ready_o[0] the same cycle → core_start_o never pulses; rsp_valid_o=4'b0001, rsp_err_o=1, rsp_result_o=0.
- Config m=0x7FE001, m_bl=23; core model returns x mod m after 25 cycles; req1 x=0x00800000: exactly one core_start_o pulse with core_x_o=0x800000, core_m_o=0x7FE001 → rsp_valid_o[1] at handshake+27, result=0x1FFF, err=0.
- All four req_valid_i high continuously: grant order 0,1,2,3. Then, with only req0 and req3 valid, the next grants are 0 then 3.
- Core model never asserts core_valid_i: timeout_o pulses after 256 WAIT cycles → rsp_err_o=1, result=0, rr_ptr advances.
- rsp_ready_i[2] held low for 10 cycles while req0 is valid: rsp_valid_o[2] and the result are stable for all 10 cycles; req_ready_o stays 0 until the response handshake.
- Config boundaries and reset:
  - cfg_we_i during WAIT: cfg_err_o pulses and core_m_o is unchanged.
  - cfg_m_bl_i=0 in IDLE: cfg_err_o pulses.
  - rst_ni low mid-WAIT: all outputs 0 and the dropped job produces no response.
  - After config and a new request, the first grant is requester 0.

Source files
------------

// File: rtl/montgomery_job_sched.sv
// Round-robin front end sharing one bit-serial Montgomery core among NUM_REQ clients.
// It holds the modulus configuration, runs one job at a time, and aborts a job whose core never answers.
module montgomery_job_sched #(
  parameter int DATA_LENGTH    = 64,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_we_i,
  input  logic [DATA_LENGTH-1:0]         cfg_m_i,
  input  logic [DATA_LENGTH-1:0]         cfg_minv_i,
  input  logic [DATA_LENGTH-1:0]         cfg_m_bl_i,
  output logic                           cfg_err_o,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_x_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [DATA_LENGTH-1:0]         rsp_result_o,
  output logic                           rsp_err_o,
  output logic                           core_start_o,
  output logic [DATA_LENGTH-1:0]         core_x_o,
  output logic [DATA_LENGTH-1:0]         core_m_o,
  output logic [DATA_LENGTH-1:0]         core_minv_o,
  output logic [DATA_LENGTH-1:0]         core_m_bl_o,
  input  logic [DATA_LENGTH-1:0]         core_result_i,
  input  logic                           core_valid_i,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [DATA_LENGTH-1:0] BL_MAX  = DATA_LENGTH'(DATA_LENGTH);
  localparam logic [TW-1:0]          CNT_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0]          GNT_MAX = PW'(NUM_REQ - 1);

  logic [1:0]             state_reg;
  logic [PW-1:0]          rr_ptr_reg;
  logic [PW-1:0]          gnt_reg;
  logic [DATA_LENGTH-1:0] x_reg;
  logic [DATA_LENGTH-1:0] result_reg;
  logic                   err_reg;
  logic [TW-1:0]          cnt_reg;
  logic                   cfg_valid_reg;
  logic [DATA_LENGTH-1:0] cfg_m_reg;
  logic [DATA_LENGTH-1:0] cfg_minv_reg;
  logic [DATA_LENGTH-1:0] cfg_m_bl_reg;
  logic                   cfg_err_reg;
  logic                   timeout_reg;

  logic                   any_req;
  logic [PW-1:0]          gnt_idx;
  logic                   cfg_ok;
  logic                   cfg_valid_next;
  logic [DATA_LENGTH-1:0] sel_x;

  // Search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    int idx;
    logic [PW-1:0] idx_v;
    any_req = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_v   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = PW'(idx);
      if (!any_req && req_valid_i[idx_v]) begin
        any_req = 1'b1;
        gnt_idx = idx_v;
      end
    end
  end

  assign sel_x = req_x_i[gnt_idx*DATA_LENGTH +: DATA_LENGTH];

  // A config write landing in the same IDLE cycle as a grant already counts for that job.
  assign cfg_ok = cfg_we_i && (state_reg == ST_IDLE) &&
                  (cfg_m_bl_i != '0) && (cfg_m_bl_i <= BL_MAX);
  assign cfg_valid_next = cfg_valid_reg | cfg_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      gnt_reg       <= '0;
      x_reg         <= '0;
      result_reg    <= '0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
      cfg_valid_reg <= 1'b0;
      cfg_m_reg     <= '0;
      cfg_minv_reg  <= '0;
      cfg_m_bl_reg  <= '0;
      cfg_err_reg   <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_we_i && !cfg_ok;
      timeout_reg <= 1'b0;
      if (cfg_ok) begin
        cfg_m_reg     <= cfg_m_i;
        cfg_minv_reg  <= cfg_minv_i;
        cfg_m_bl_reg  <= cfg_m_bl_i;
        cfg_valid_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            x_reg   <= sel_x;
            gnt_reg <= gnt_idx;
            if (cfg_valid_next) begin
              state_reg <= ST_START;
            end else begin
              result_reg <= '0;
              err_reg    <= 1'b1;
              state_reg  <= ST_RESP;
            end
          end
        end
        ST_START: begin
          cnt_reg   <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the last allowed cycle still beats the abort.
          if (core_valid_i) begin
            result_reg <= core_result_i;
            err_reg    <= 1'b0;
            state_reg  <= ST_RESP;
          end else if (cnt_reg == CNT_MAX) begin
            timeout_reg <= 1'b1;
            result_reg  <= '0;
            err_reg     <= 1'b1;
            state_reg   <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + TW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i[gnt_reg]) begin
            rr_ptr_reg <= (gnt_reg == GNT_MAX) ? '0 : gnt_reg + PW'(1);
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (state_reg == ST_IDLE && any_req) req_ready_o[gnt_idx] = 1'b1;
    if (state_reg == ST_RESP) rsp_valid_o[gnt_reg] = 1'b1;
  end

  assign rsp_result_o = (state_reg == ST_RESP) ? result_reg : '0;
  assign rsp_err_o    = (state_reg == ST_RESP) && err_reg;
  assign core_start_o = (state_reg == ST_START);
  assign core_x_o     = x_reg;
  assign core_m_o     = cfg_m_reg;
  assign core_minv_o  = cfg_minv_reg;
  assign core_m_bl_o  = cfg_m_bl_reg;
  assign busy_o       = (state_reg != ST_IDLE);
  assign timeout_o    = timeout_reg;
  assign cfg_err_o    = cfg_err_reg;

endmodule

// File: tb/tb_montgomery_job_sched.sv
// Directed bench for montgomery_job_sched: a vector table of single jobs plus
// hand-written sequences for arbitration, back-pressure, config rejects and reset.
module tb_montgomery_job_sched;
  localparam int DL = 64;
  localparam int NR = 4;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           cfg_we_i;
  logic [DL-1:0]  cfg_m_i, cfg_minv_i, cfg_m_bl_i;
  logic           cfg_err_o;
  logic [NR-1:0]  req_valid_i;
  logic [NR*DL-1:0] req_x_i;
  logic [NR-1:0]  req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [DL-1:0]  rsp_result_o;
  logic           rsp_err_o, core_start_o;
  logic [DL-1:0]  core_x_o, core_m_o, core_minv_o, core_m_bl_o, core_result_i;
  logic           core_valid_i, busy_o, timeout_o;

  int checks = 0;
  int errors = 0;

  montgomery_job_sched #(.DATA_LENGTH(DL), .NUM_REQ(NR), .TIMEOUT_CYCLES(256)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_m_i(cfg_m_i), .cfg_minv_i(cfg_minv_i), .cfg_m_bl_i(cfg_m_bl_i),
    .cfg_err_o(cfg_err_o),
    .req_valid_i(req_valid_i), .req_x_i(req_x_i), .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_err_o(rsp_err_o),
    .core_start_o(core_start_o), .core_x_o(core_x_o), .core_m_o(core_m_o),
    .core_minv_o(core_minv_o), .core_m_bl_o(core_m_bl_o),
    .core_result_i(core_result_i), .core_valid_i(core_valid_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // Core model: answers x mod m, core_lat cycles after the start cycle, unless core_never.
  int            core_lat = 25;
  bit            core_never = 1'b0;
  int            core_cnt = 0;
  logic [DL-1:0] core_res_q = '0;
  always @(posedge clk_i) begin
    if (core_start_o && !core_never) begin
      core_cnt   <= core_lat;
      core_res_q <= (core_m_o != '0) ? core_x_o % core_m_o : '0;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign core_valid_i  = (core_cnt == 1);
  assign core_result_i = core_res_q;

  task automatic chk(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_x(input int r, input logic [DL-1:0] v);
    req_x_i[r*DL +: DL] = v;
  endtask

  task automatic cfg_write(input logic [DL-1:0] m, input logic [DL-1:0] bl,
                           input logic exp_err, input string name);
    @(posedge clk_i); #1;
    cfg_we_i = 1'b1; cfg_m_i = m; cfg_minv_i = m ^ 64'h5A5A; cfg_m_bl_i = bl;
    @(posedge clk_i); #1;
    cfg_we_i = 1'b0;
    @(negedge clk_i);
    $display("cfg write m=0x%0h bl=%0d cfg_err=%b", m, bl, cfg_err_o);
    chk({name, "_err"}, DL'(cfg_err_o), DL'(exp_err));
    @(negedge clk_i);
    chk({name, "_err_1cyc"}, DL'(cfg_err_o), '0);
  endtask

  // Raises req_valid mask for one IDLE cycle, then tracks the job up to its first RESP cycle.
  task automatic run_job(input logic [NR-1:0] mask, output logic [NR-1:0] gnt_oh,
                         output int lat, output int starts, output logic [DL-1:0] sx,
                         output logic [DL-1:0] sm, output logic [DL-1:0] res,
                         output logic err, output logic to_seen);
    bit got;
    gnt_oh = '0; lat = -1; starts = 0; sx = '0; sm = '0; res = '0; err = 1'b0; to_seen = 1'b0;
    @(posedge clk_i); #1;
    req_valid_i = mask;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (req_ready_o != '0) begin
        got = 1'b1;
        gnt_oh = req_ready_o;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL grant_wait: got no req_ready_o, expected a grant within 20 cycles");
      req_valid_i = '0;
      return;
    end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    for (int n = 1; n <= 400; n++) begin
      if (n > 1) @(posedge clk_i);
      @(negedge clk_i);
      if (core_start_o) begin starts++; sx = core_x_o; sm = core_m_o; end
      if (timeout_o) to_seen = 1'b1;
      if (rsp_valid_o != '0) begin
        lat = n; res = rsp_result_o; err = rsp_err_o;
        chk("rsp_onehot", DL'(rsp_valid_o), DL'(gnt_oh));
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL rsp_wait: got no rsp_valid_o, expected one within 400 cycles");
    end
    $display("job mask=%b gnt=%b lat=%0d starts=%0d res=0x%0h err=%b timeout=%b",
             mask, gnt_oh, lat, starts, res, err, to_seen);
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    logic [DL-1:0] x;
    int            lat;
    bit            never;
    logic [DL-1:0] exp_res;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [NR-1:0] g;
    int lat, starts;
    logic [DL-1:0] sx, sm, res, held;
    logic err, tos;
    int rsp_seen;

    vecs[0] = '{4'b0010, 64'h800000,   25, 1'b0, 64'h1FFF, 1'b0, 27};
    vecs[1] = '{4'b0100, 64'h123,       1, 1'b0, 64'h123,  1'b0, 3};
    vecs[2] = '{4'b1000, 64'hFFFFFF,    5, 1'b0, 64'h3FFD, 1'b0, 7};
    vecs[3] = '{4'b0001, 64'h7FE001,    3, 1'b0, 64'h0,    1'b0, 5};
    vecs[4] = '{4'b0100, 64'h5,         1, 1'b1, 64'h0,    1'b1, 258};
    vecs[5] = '{4'b1000, 64'h7FE002,    2, 1'b0, 64'h1,    1'b0, 4};

    rst_ni = 1'b0; cfg_we_i = 1'b0; cfg_m_i = '0; cfg_minv_i = '0; cfg_m_bl_i = '0;
    req_valid_i = '0; req_x_i = '0; rsp_ready_i = '1;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", DL'(busy_o), '0);
    chk("rst_core_start", DL'(core_start_o), '0);
    chk("rst_core_m", core_m_o, '0);
    chk("rst_rsp_valid", DL'(rsp_valid_o), '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Job with no configuration loaded: immediate error response, core untouched.
    set_x(0, 64'h10);
    run_job(4'b0001, g, lat, starts, sx, sm, res, err, tos);
    chk("nocfg_gnt", DL'(g), 64'h1);
    chk("nocfg_lat", DL'(lat), 64'd1);
    chk("nocfg_starts", DL'(starts), '0);
    chk("nocfg_err", DL'(err), 64'h1);
    chk("nocfg_res", res, '0);

    cfg_write(64'h7FE001, 64'd23, 1'b0, "cfg_ok");
    chk("cfg_core_m", core_m_o, 64'h7FE001);
    chk("cfg_core_bl", core_m_bl_o, 64'd23);

    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < NR; r++) if (vecs[i].mask[r]) set_x(r, vecs[i].x);
      core_lat = vecs[i].lat; core_never = vecs[i].never;
      run_job(vecs[i].mask, g, lat, starts, sx, sm, res, err, tos);
      chk($sformatf("v%0d_gnt", i), DL'(g), DL'(vecs[i].mask));
      chk($sformatf("v%0d_lat", i), DL'(lat), DL'(vecs[i].exp_lat));
      chk($sformatf("v%0d_starts", i), DL'(starts), 64'd1);
      chk($sformatf("v%0d_core_x", i), sx, vecs[i].x);
      chk($sformatf("v%0d_core_m", i), sm, 64'h7FE001);
      chk($sformatf("v%0d_res", i), res, vecs[i].exp_res);
      chk($sformatf("v%0d_err", i), DL'(err), DL'(vecs[i].exp_err));
      chk($sformatf("v%0d_timeout", i), DL'(tos), DL'(vecs[i].never));
    end
    core_never = 1'b0;

    // Round-robin: all four valid, then only 0 and 3.
    core_lat = 2;
    for (int r = 0; r < NR; r++) set_x(r, 64'h100 + 64'(r));
    for (int i = 0; i < 4; i++) begin
      run_job(4'b1111, g, lat, starts, sx, sm, res, err, tos);
      chk($sformatf("rr_all_%0d", i), DL'(g), DL'(1 << i));
    end
    run_job(4'b1001, g, lat, starts, sx, sm, res, err, tos);
    chk("rr_03_first", DL'(g), 64'h1);
    run_job(4'b1001, g, lat, starts, sx, sm, res, err, tos);
    chk("rr_03_second", DL'(g), 64'h8);

    // Back-pressure on requester 2 while requester 0 waits.
    set_x(2, 64'h800000);
    rsp_ready_i = 4'b1011;
    run_job(4'b0100, g, lat, starts, sx, sm, res, err, tos);
    held = res;
    chk("bp_res", held, 64'h1FFF);
    @(posedge clk_i); #1;
    req_valid_i = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk($sformatf("bp_valid_%0d", i), DL'(rsp_valid_o), 64'h4);
      chk($sformatf("bp_result_%0d", i), rsp_result_o, held);
      chk($sformatf("bp_ready_%0d", i), DL'(req_ready_o), '0);
    end
    @(posedge clk_i); #1;
    rsp_ready_i = '1; req_valid_i = '0;
    @(negedge clk_i);
    chk("bp_last_valid", DL'(rsp_valid_o), 64'h4);
    run_job(4'b0001, g, lat, starts, sx, sm, res, err, tos);
    chk("bp_next_gnt", DL'(g), 64'h1);

    // Config write during WAIT is rejected and leaves the core operands alone.
    set_x(1, 64'h800000);
    core_lat = 25;
    @(posedge clk_i); #1;
    req_valid_i = 4'b0010;
    @(negedge clk_i);
    chk("wcfg_gnt", DL'(req_ready_o), 64'h2);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(posedge clk_i); #1;
    cfg_write(64'h11, 64'd5, 1'b1, "cfg_in_wait");
    chk("wcfg_core_m", core_m_o, 64'h7FE001);
    chk("wcfg_core_bl", core_m_bl_o, 64'd23);
    rsp_seen = 0;
    for (int i = 0; i < 60 && rsp_seen == 0; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o != '0) begin
        rsp_seen = 1;
        chk("wcfg_rsp_valid", DL'(rsp_valid_o), 64'h2);
        chk("wcfg_res", rsp_result_o, 64'h1FFF);
        chk("wcfg_err", DL'(rsp_err_o), '0);
      end
    end
    chk("wcfg_rsp_seen", DL'(rsp_seen), 64'd1);

    // Reset in the middle of WAIT drops the job.
    set_x(2, 64'h123);
    @(posedge clk_i); #1;
    req_valid_i = 4'b0100;
    @(negedge clk_i);
    chk("rstw_gnt", DL'(req_ready_o), 64'h4);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rstw_busy_before", DL'(busy_o), 64'h1);
    rst_ni = 1'b0;
    #1;
    chk("rstw_busy", DL'(busy_o), '0);
    chk("rstw_core_x", core_x_o, '0);
    chk("rstw_core_m", core_m_o, '0);
    chk("rstw_rsp_valid", DL'(rsp_valid_o), '0);
    chk("rstw_rsp_result", rsp_result_o, '0);
    chk("rstw_timeout", DL'(timeout_o), '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o != '0 || busy_o) rsp_seen++;
    end
    chk("rstw_no_rsp", DL'(rsp_seen), '0);

    // Bit-length bounds, then a fresh config: first grant goes to requester 0.
    cfg_write(64'h7FE001, 64'd0, 1'b1, "cfg_bl0");
    cfg_write(64'h7FE001, 64'd65, 1'b1, "cfg_bl65");
    chk("cfg_rej_bl", core_m_bl_o, '0);
    cfg_write(64'h7FE001, 64'd64, 1'b0, "cfg_bl64");
    for (int r = 0; r < NR; r++) set_x(r, 64'h100 + 64'(r));
    core_lat = 4;
    run_job(4'b1111, g, lat, starts, sx, sm, res, err, tos);
    chk("post_rst_gnt", DL'(g), 64'h1);
    chk("post_rst_res", res, 64'h100);
    chk("post_rst_lat", DL'(lat), 64'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before 500000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
